// File: rtl/tnt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : tnt_pkg                                                    |
// | Description : Shared types and signed clamp/saturate helpers for the     |
// |               token emitter.                                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tnt_pkg;

  // Working width for all emitter arithmetic. It must cover
  // PENDING_BITS + clog2(NUM_SOURCES) + 1 so that summing contributions and
  // adding the backlog never wraps before the final clamp.
  localparam int TNT_ACC_W = 32;

  // Widened signed type carrying per-source contributions and the delta sum.
  typedef logic signed [TNT_ACC_W-1:0] tnt_contrib_t;

  // Default widths of the output increment and the pending accumulator.
  localparam int TNT_NEW_TOKENS_BITS_DEF = 4;
  localparam int TNT_PENDING_BITS_DEF    = 8;

  // Largest value representable in a signed field of the given width.
  function automatic tnt_contrib_t tnt_smax(input int unsigned width);
    tnt_smax = (tnt_contrib_t'(1) <<< (width - 1)) - tnt_contrib_t'(1);
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic tnt_contrib_t tnt_smin(input int unsigned width);
    tnt_smin = -(tnt_contrib_t'(1) <<< (width - 1));
  endfunction

  // Clamp a signed value into [lo, hi].
  function automatic tnt_contrib_t tnt_clamp(input tnt_contrib_t value,
                                             input tnt_contrib_t lo,
                                             input tnt_contrib_t hi);
    if (value > hi) begin
      tnt_clamp = hi;
    end else if (value < lo) begin
      tnt_clamp = lo;
    end else begin
      tnt_clamp = value;
    end
  endfunction

  // Saturate a signed value into the range of a signed field of 'width' bits.
  function automatic tnt_contrib_t tnt_sat(input tnt_contrib_t value,
                                           input int unsigned width);
    tnt_sat = tnt_clamp(value, tnt_smin(width), tnt_smax(width));
  endfunction

  // Default-width range limits, for reference by integrators.
  localparam tnt_contrib_t TNT_EMIT_MAX_DEF = tnt_smax(TNT_NEW_TOKENS_BITS_DEF);
  localparam tnt_contrib_t TNT_EMIT_MIN_DEF = tnt_smin(TNT_NEW_TOKENS_BITS_DEF);
  localparam tnt_contrib_t TNT_PEND_MAX_DEF = tnt_smax(TNT_PENDING_BITS_DEF);
  localparam tnt_contrib_t TNT_PEND_MIN_DEF = tnt_smin(TNT_PENDING_BITS_DEF);

endpackage : tnt_pkg
`default_nettype wire

// File: rtl/tnt_emitter_source.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tnt_emitter_source                                         |
// | Description : One upstream source: tracks the token-present bit from     |
// |               start/end pulses and produces a signed contribution.       |
// |               Macro TNT_EMITTER_SUSTAIN_EN selects sustained drive        |
// |               (contribute +w every cycle while active) instead of the    |
// |               default impulse behaviour (+w on start, -w on end).        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tnt_emitter_source
  import tnt_pkg::*;
#(
  parameter int WEIGHT_BITS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          end_i,
  input  logic signed [WEIGHT_BITS-1:0] weight_i,
  output logic                          active_o,
  output tnt_contrib_t                  contrib_o
);

  logic         active_q;
  logic         active_d;
  logic         w_accept_start;
  logic         w_accept_end;
  tnt_contrib_t w_weight_ext;

  assign w_weight_ext = tnt_contrib_t'(weight_i);

  // Acceptance rules: redundant events and simultaneous start+end are no-ops.
  always_comb begin
    w_accept_start = start_i & ~end_i & ~active_q;
    w_accept_end   = end_i & ~start_i & active_q;
    active_d       = active_q;
    if (w_accept_start) begin
      active_d = 1'b1;
    end else if (w_accept_end) begin
      active_d = 1'b0;
    end
  end

`ifdef TNT_EMITTER_SUSTAIN_EN
  // Sustained drive: push +w every cycle the registered state says active;
  // the acceptance result only moves the state, it adds no impulse.
  always_comb begin
    contrib_o = active_q ? w_weight_ext : '0;
  end
`else
  // Impulse drive: a single +w on accepted start, -w on accepted end.
  always_comb begin
    contrib_o = '0;
    if (w_accept_start) begin
      contrib_o = w_weight_ext;
    end else if (w_accept_end) begin
      contrib_o = -w_weight_ext;
    end
  end
`endif

  // Token-present register; reset drops any in-flight token.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
    end else begin
      active_q <= active_d;
    end
  end

  assign active_o = active_q;

endmodule : tnt_emitter_source
`default_nettype wire

// File: rtl/tnt_token_emitter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tnt_token_emitter                                          |
// | Description : Converts token start/end pulses from NUM_SOURCES upstream  |
// |               processors into signed per-cycle token increments,         |
// |               buffering excess in a saturating pending accumulator and   |
// |               draining it through a narrow saturated output.             |
// |               Optional macro TNT_EMITTER_SUSTAIN_EN (see                 |
// |               tnt_emitter_source) enables sustained drive.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tnt_token_emitter
  import tnt_pkg::*;
#(
  parameter int NUM_SOURCES     = 4,
  parameter int WEIGHT_BITS     = 4,
  parameter int NEW_TOKENS_BITS = TNT_NEW_TOKENS_BITS_DEF,
  parameter int PENDING_BITS    = TNT_PENDING_BITS_DEF
) (
  input  logic                                 clock_fast,
  input  logic                                 reset,
  input  logic        [NUM_SOURCES-1:0]        token_start,
  input  logic        [NUM_SOURCES-1:0]        token_end,
  input  logic        [NUM_SOURCES*WEIGHT_BITS-1:0] weights,
  input  logic                                 enable,
  input  logic                                 clear_overflow,
  output logic signed [NEW_TOKENS_BITS-1:0]    new_tokens,
  output logic signed [PENDING_BITS-1:0]       pending,
  output logic        [NUM_SOURCES-1:0]        active,
  output logic                                 overflow
);

  localparam tnt_contrib_t c_EMIT_MAX = tnt_smax(NEW_TOKENS_BITS);
  localparam tnt_contrib_t c_EMIT_MIN = tnt_smin(NEW_TOKENS_BITS);
  localparam tnt_contrib_t c_PEND_MAX = tnt_smax(PENDING_BITS);
  localparam tnt_contrib_t c_PEND_MIN = tnt_smin(PENDING_BITS);

  tnt_contrib_t                       w_contrib [NUM_SOURCES];
  tnt_contrib_t                       w_delta;
  tnt_contrib_t                       w_total;
  tnt_contrib_t                       w_emit;
  tnt_contrib_t                       w_rem;
  tnt_contrib_t                       w_pend_sat;
  logic                               w_sat_hit;

  logic signed [NEW_TOKENS_BITS-1:0]  new_tokens_q;
  logic signed [NEW_TOKENS_BITS-1:0]  new_tokens_d;
  logic signed [PENDING_BITS-1:0]     pending_q;
  logic signed [PENDING_BITS-1:0]     pending_d;
  logic                               overflow_q;
  logic                               overflow_d;

  // One acceptance/contribution slice per upstream source.
  for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
    tnt_emitter_source #(
      .WEIGHT_BITS (WEIGHT_BITS)
    ) u_src (
      .clk_i     (clock_fast),
      .rst_i     (reset),
      .start_i   (token_start[gi]),
      .end_i     (token_end[gi]),
      .weight_i  (weights[gi*WEIGHT_BITS +: WEIGHT_BITS]),
      .active_o  (active[gi]),
      .contrib_o (w_contrib[gi])
    );
  end : g_src

  // Sum contributions, split the total into emit and residual backlog, and
  // saturate the backlog. Emit is clamped from total, so it never has the
  // opposite sign of total and draining alone cannot flip the backlog sign.
  always_comb begin
    w_delta = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      w_delta = w_delta + w_contrib[i];
    end
    w_total = tnt_contrib_t'(pending_q) + w_delta;

    if (enable) begin
      w_emit = tnt_clamp(w_total, c_EMIT_MIN, c_EMIT_MAX);
    end else begin
      w_emit = '0;
    end
    w_rem      = w_total - w_emit;
    w_pend_sat = tnt_clamp(w_rem, c_PEND_MIN, c_PEND_MAX);
    w_sat_hit  = (w_pend_sat != w_rem);

    new_tokens_d = NEW_TOKENS_BITS'(w_emit);
    pending_d    = PENDING_BITS'(w_pend_sat);
    // A saturation event takes priority over a clear in the same cycle.
    overflow_d   = w_sat_hit | (overflow_q & ~clear_overflow);
  end

  // Output and backlog registers; reset discards the backlog immediately.
  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      new_tokens_q <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      new_tokens_q <= new_tokens_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
    end
  end

  assign new_tokens = new_tokens_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule : tnt_token_emitter
`default_nettype wire

// File: tb/tb_tnt_token_emitter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tnt_token_emitter                                       |
// | Description : Self-checking bench for tnt_token_emitter. A reference     |
// |               model predicts every cycle into a scoreboard queue; each   |
// |               test pops and compares, plus fixed expected sequences.     |
// |               Build with TNT_EMITTER_SUSTAIN_EN to exercise sustain mode.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tnt_token_emitter;

  localparam int NS = 4;
  localparam int WB = 4;
  localparam int NT = 4;
  localparam int PB = 8;

  logic                    clock_fast = 1'b0;
  logic                    reset      = 1'b1;
  logic [NS-1:0]           token_start = '0;
  logic [NS-1:0]           token_end   = '0;
  logic [NS*WB-1:0]        weights     = '0;
  logic                    enable      = 1'b0;
  logic                    clear_overflow = 1'b0;
  logic signed [NT-1:0]    new_tokens;
  logic signed [PB-1:0]    pending;
  logic [NS-1:0]           active;
  logic                    overflow;

  typedef struct packed {
    logic signed [NT-1:0] nt;
    logic signed [PB-1:0] pend;
    logic [NS-1:0]        act;
    logic                 ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [NS-1:0] m_act  = '0;
  int            m_pend = 0;
  logic          m_ovf  = 1'b0;

  tnt_token_emitter #(
    .NUM_SOURCES     (NS),
    .WEIGHT_BITS     (WB),
    .NEW_TOKENS_BITS (NT),
    .PENDING_BITS    (PB)
  ) dut (
    .clock_fast     (clock_fast),
    .reset          (reset),
    .token_start    (token_start),
    .token_end      (token_end),
    .weights        (weights),
    .enable         (enable),
    .clear_overflow (clear_overflow),
    .new_tokens     (new_tokens),
    .pending        (pending),
    .active         (active),
    .overflow       (overflow)
  );

  always #5 clock_fast = ~clock_fast;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [NS*WB-1:0] wpack(input int w0, input int w1,
                                             input int w2, input int w3);
    logic [WB-1:0] a, b, c, d;
    a = WB'(w0); b = WB'(w1); c = WB'(w2); d = WB'(w3);
    wpack = {d, c, b, a};
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) clampi = hi;
    else if (v < lo) clampi = lo;
    else clampi = v;
  endfunction

  // Drive one cycle of stimulus, advance the model, push the prediction.
  task automatic drive(input logic [NS-1:0] s, input logic [NS-1:0] e,
                       input logic [NS*WB-1:0] w, input logic en,
                       input logic clr);
    int   delta, total, emit, rem, np, wi;
    exp_t x;
    @(negedge clock_fast);
    token_start = s; token_end = e; weights = w;
    enable = en; clear_overflow = clr;
    delta = 0;
    for (int i = 0; i < NS; i++) begin
      wi = int'($signed(w[i*WB +: WB]));
`ifdef TNT_EMITTER_SUSTAIN_EN
      if (m_act[i]) delta += wi;
      if (s[i] && !e[i] && !m_act[i]) m_act[i] = 1'b1;
      else if (e[i] && !s[i] && m_act[i]) m_act[i] = 1'b0;
`else
      if (s[i] && !e[i] && !m_act[i]) begin
        delta += wi; m_act[i] = 1'b1;
      end else if (e[i] && !s[i] && m_act[i]) begin
        delta -= wi; m_act[i] = 1'b0;
      end
`endif
    end
    total = m_pend + delta;
    emit  = en ? clampi(total, -(1 << (NT-1)), (1 << (NT-1)) - 1) : 0;
    rem   = total - emit;
    np    = clampi(rem, -(1 << (PB-1)), (1 << (PB-1)) - 1);
    if (np != rem) m_ovf = 1'b1;
    else if (clr)  m_ovf = 1'b0;
    m_pend = np;
    x.nt = NT'(emit); x.pend = PB'(np); x.act = m_act; x.ovf = m_ovf;
    sb_q.push_back(x);
    @(posedge clock_fast);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock_fast);
    #1;
    n_checks++;
    if ({new_tokens, pending, active, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got nt=%0d pend=%0d act=%b ovf=%b, required all zero",
               new_tokens, pending, active, overflow);
    end
    @(negedge clock_fast);
    reset = 1'b0;
    m_act = '0; m_pend = 0; m_ovf = 1'b0;
  endtask

  task automatic test_impulse();
    exp_t x;
    int   exp_nt [4] = '{3, 0, -3, 0};
    logic exp_a0 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      drive(k == 0 ? 4'b0001 : 4'b0000, k == 2 ? 4'b0001 : 4'b0000,
            wpack(3, 0, 0, 0), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x) begin
        n_fail++;
        $display("FAIL impulse_sb step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
      n_checks++;
      if (int'(new_tokens) != exp_nt[k] || active[0] !== exp_a0[k]) begin
        n_fail++;
        $display("FAIL impulse_seq step %0d: got nt=%0d act0=%b, required nt=%0d act0=%b",
                 k, new_tokens, active[0], exp_nt[k], exp_a0[k]);
      end
    end
  endtask

  task automatic test_drain();
    exp_t x;
    int   exp_nt [4] = '{7, 7, 6, 0};
    int   exp_p  [4] = '{13, 6, 0, 0};
    for (int k = 0; k < 4; k++) begin
      drive(k == 0 ? 4'b1111 : 4'b0000, 4'b0000, wpack(5, 5, 5, 5), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x) begin
        n_fail++;
        $display("FAIL drain_sb step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
      n_checks++;
      if (int'(new_tokens) != exp_nt[k] || int'(pending) != exp_p[k]) begin
        n_fail++;
        $display("FAIL drain_seq step %0d: got nt=%0d pend=%0d, required nt=%0d pend=%0d",
                 k, new_tokens, pending, exp_nt[k], exp_p[k]);
      end
    end
    // Withdraw all four: negative backlog drains without changing sign.
    for (int k = 0; k < 4; k++) begin
      drive(4'b0000, k == 0 ? 4'b1111 : 4'b0000, wpack(5, 5, 5, 5), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x || pending > 0) begin
        n_fail++;
        $display("FAIL drain_neg step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
    end
  endtask

  task automatic test_redundant();
    exp_t          x;
    logic [NS-1:0] s_tab [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    logic [NS-1:0] e_tab [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010};
    int            exp_nt [7] = '{-2, 0, 2, 0, 0, -2, 2};
    logic          exp_a1 [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 7; k++) begin
      drive(s_tab[k], e_tab[k], wpack(0, -2, 0, 0), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x) begin
        n_fail++;
        $display("FAIL redundant_sb step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
      n_checks++;
      if (int'(new_tokens) != exp_nt[k] || active[1] !== exp_a1[k]) begin
        n_fail++;
        $display("FAIL redundant_seq step %0d: got nt=%0d act1=%b, required nt=%0d act1=%b",
                 k, new_tokens, active[1], exp_nt[k], exp_a1[k]);
      end
    end
    // Simultaneous start+end while active must leave active set.
    drive(4'b0010, 4'b0000, wpack(0, -2, 0, 0), 1'b1, 1'b0);
    x = sb_q.pop_front();
    drive(4'b0010, 4'b0010, wpack(0, -2, 0, 0), 1'b1, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({new_tokens, pending, active, overflow} !== x || active[1] !== 1'b1 || new_tokens !== 4'sd0) begin
      n_fail++;
      $display("FAIL redundant_both_active: got nt=%0d act=%b, required nt=0 act1=1 (model act=%b)",
               new_tokens, active, x.act);
    end
    drive(4'b0000, 4'b0010, wpack(0, -2, 0, 0), 1'b1, 1'b0);
    x = sb_q.pop_front();
  endtask

  task automatic test_overflow();
    exp_t          x;
    logic [NS-1:0] s_tab [9]  = '{4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
    logic [NS-1:0] e_tab [9]  = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF};
    int            w_tab [9]  = '{7, -7, 7, -7, 7, -7, 7, 7, 7};
    logic          c_tab [9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int            exp_p [9]  = '{28, 56, 84, 112, 127, 127, 127, 127, 99};
    logic          exp_o [9]  = '{0, 0, 0, 0, 1, 1, 0, 1, 0};
    for (int k = 0; k < 9; k++) begin
      drive(s_tab[k], e_tab[k], wpack(w_tab[k], w_tab[k], w_tab[k], w_tab[k]),
            1'b0, c_tab[k]);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x) begin
        n_fail++;
        $display("FAIL overflow_sb step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
      n_checks++;
      if (int'(pending) != exp_p[k] || overflow !== exp_o[k] || new_tokens !== 4'sd0) begin
        n_fail++;
        $display("FAIL overflow_seq step %0d: got pend=%0d ovf=%b nt=%0d, required pend=%0d ovf=%b nt=0",
                 k, pending, overflow, new_tokens, exp_p[k], exp_o[k]);
      end
    end
    // Drain the positive backlog: every emit is non-negative.
    for (int k = 0; k < 16; k++) begin
      drive(4'h0, 4'h0, wpack(7, 7, 7, 7), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x || new_tokens < 0) begin
        n_fail++;
        $display("FAIL overflow_drain step %0d: got nt=%0d pend=%0d, required nt=%0d pend=%0d",
                 k, new_tokens, pending, x.nt, x.pend);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t x;
    drive(4'hF, 4'h0, wpack(5, 5, 5, 5), 1'b0, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({new_tokens, pending, active, overflow} !== x || pending !== 8'sd20) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got pend=%0d act=%b, required pend=20 act=%b",
               pending, active, x.act);
    end
    @(negedge clock_fast);
    token_start = '0; enable = 1'b1;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({new_tokens, pending, active, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got nt=%0d pend=%0d act=%b ovf=%b, required all zero",
               new_tokens, pending, active, overflow);
    end
    @(negedge clock_fast);
    reset = 1'b0;
    m_act = '0; m_pend = 0; m_ovf = 1'b0;
    sb_q.delete();
    drive(4'h0, 4'h0, wpack(5, 5, 5, 5), 1'b1, 1'b0);
    x = sb_q.pop_front();
    n_checks++;
    if ({new_tokens, pending, active, overflow} !== x || x !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got nt=%0d pend=%0d act=%b ovf=%b, required all zero",
               new_tokens, pending, active, overflow);
    end
  endtask

`ifdef TNT_EMITTER_SUSTAIN_EN
  task automatic test_sustain();
    exp_t x;
    int   exp_nt [6] = '{0, 2, 2, 2, 2, 0};
    for (int k = 0; k < 6; k++) begin
      drive(k == 0 ? 4'b0001 : 4'b0000, k == 4 ? 4'b0001 : 4'b0000,
            wpack(2, 0, 0, 0), 1'b1, 1'b0);
      x = sb_q.pop_front();
      n_checks++;
      if ({new_tokens, pending, active, overflow} !== x) begin
        n_fail++;
        $display("FAIL sustain_sb step %0d: got nt=%0d pend=%0d act=%b ovf=%b, required nt=%0d pend=%0d act=%b ovf=%b",
                 k, new_tokens, pending, active, overflow, x.nt, x.pend, x.act, x.ovf);
      end
      n_checks++;
      if (int'(new_tokens) != exp_nt[k]) begin
        n_fail++;
        $display("FAIL sustain_seq step %0d: got nt=%0d, required nt=%0d",
                 k, new_tokens, exp_nt[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TNT_EMITTER_SUSTAIN_EN
    test_sustain();
`else
    test_impulse();
    test_drain();
    test_redundant();
    test_overflow();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tnt_token_emitter
`default_nettype wire
